// File: rtl/lcd_bus_rx.sv
// Receiver for the 4-wire LCD link: deserialises {rs,byte} words and decodes CASET/RASET/RAMWR
// into addressed RGB565 pixels. Define LCD_RX_SYNC_EN to add 2-flop synchronisers for async links.
module lcd_bus_rx #(
    parameter int unsigned H_RES       = 240,
    parameter int unsigned V_RES       = 320,
    parameter int unsigned COORD_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lcd_sck,
    input  logic                   lcd_sd,
    input  logic                   lcd_cs,
    input  logic                   lcd_rs,
    output logic                   word_valid,
    output logic [8:0]             word_data,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_data,
    output logic                   pix_valid,
    output logic [15:0]            pix_data,
    output logic [COORD_WIDTH-1:0] pix_x,
    output logic [COORD_WIDTH-1:0] pix_y,
    output logic                   param_err
);

    localparam int unsigned CW = COORD_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CASET = 2'd1;
    localparam logic [1:0] ST_RASET = 2'd2;
    localparam logic [1:0] ST_RAMWR = 2'd3;

    localparam logic [7:0] OP_CASET = 8'h2A;
    localparam logic [7:0] OP_RASET = 8'h2B;
    localparam logic [7:0] OP_RAMWR = 8'h2C;

    // Pin vector order {sck, sd, cs, rs}; cs idles deasserted so reset never fakes an edge.
    localparam logic [3:0] PIN_IDLE = 4'b0010;

    logic [3:0] pins_c;
    logic [3:0] samp_q;
    logic       sck_p_q;
    logic       cs_p_q;

`ifdef LCD_RX_SYNC_EN
    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= PIN_IDLE;
            sync_q <= PIN_IDLE;
        end else begin
            meta_q <= {lcd_sck, lcd_sd, lcd_cs, lcd_rs};
            sync_q <= meta_q;
        end
    end

    assign pins_c = sync_q;
`else
    assign pins_c = {lcd_sck, lcd_sd, lcd_cs, lcd_rs};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q  <= PIN_IDLE;
            sck_p_q <= 1'b0;
            cs_p_q  <= 1'b1;
        end else begin
            samp_q  <= pins_c;
            sck_p_q <= samp_q[3];
            cs_p_q  <= samp_q[1];
        end
    end

    // cs is qualified one sample late so an edge coinciding with cs deassert still counts.
    logic rise_c;
    assign rise_c = samp_q[3] & ~sck_p_q & ~cs_p_q;

    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       word_valid_q, word_valid_d;
    logic [8:0] word_data_q, word_data_d;

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        if (rise_c) begin
            shift_d = {shift_q[6:0], samp_q[2]};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                word_valid_d = 1'b1;
                word_data_d  = {samp_q[0], shift_q[6:0], samp_q[2]};
            end
        end else if (samp_q[1]) begin
            cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= 8'd0;
            cnt_q        <= 3'd0;
            word_valid_q <= 1'b0;
            word_data_q  <= 9'd0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
        end
    end

    // Window registers keep only the low CW bits of each 16-bit parameter pair.
    function automatic logic [CW-1:0] load_byte(input logic [CW-1:0] cur, input logic [7:0] b,
                                                input logic hi);
        logic [15:0] t;
        t = 16'(cur);
        if (hi) t[15:8] = b;
        else    t[7:0]  = b;
        return CW'(t);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          tog_q, tog_d;
    logic [7:0]    hi_q, hi_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_data_q, cmd_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic [15:0]   pix_data_q, pix_data_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          param_err_q, param_err_d;
    logic [7:0]    byte_c;

    assign byte_c = word_data_q[7:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        x_d         = x_q;
        y_d         = y_q;
        tog_d       = tog_q;
        hi_d        = hi_q;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data_q;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        param_err_d = 1'b0;
        if (word_valid_q) begin
            if (!word_data_q[8]) begin
                cmd_valid_d = 1'b1;
                cmd_data_d  = byte_c;
                param_err_d = ((state_q == ST_CASET) || (state_q == ST_RASET)) && (idx_q != 2'd0);
                idx_d       = 2'd0;
                case (byte_c)
                    OP_CASET: state_d = ST_CASET;
                    OP_RASET: state_d = ST_RASET;
                    OP_RAMWR: begin
                        state_d = ST_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                        tog_d   = 1'b0;
                    end
                    default:  state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        if (state_q == ST_CASET) begin
                            if (!idx_q[1]) xs_d = load_byte(xs_q, byte_c, ~idx_q[0]);
                            else           xe_d = load_byte(xe_q, byte_c, ~idx_q[0]);
                        end else begin
                            if (!idx_q[1]) ys_d = load_byte(ys_q, byte_c, ~idx_q[0]);
                            else           ye_d = load_byte(ye_q, byte_c, ~idx_q[0]);
                        end
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = ST_IDLE;
                    end
                    ST_RAMWR: begin
                        if (!tog_q) begin
                            hi_d  = byte_c;
                            tog_d = 1'b1;
                        end else begin
                            tog_d       = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_data_d  = {hi_q, byte_c};
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                            if (x_q == xe_q) begin
                                x_d = xs_q;
                                y_d = (y_q == ye_q) ? ys_q : y_q + CW'(1);
                            end else begin
                                x_d = x_q + CW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            xs_q        <= '0;
            xe_q        <= CW'(H_RES - 1);
            ys_q        <= '0;
            ye_q        <= CW'(V_RES - 1);
            x_q         <= '0;
            y_q         <= '0;
            tog_q       <= 1'b0;
            hi_q        <= 8'd0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= 16'd0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            param_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            x_q         <= x_d;
            y_q         <= y_d;
            tog_q       <= tog_d;
            hi_q        <= hi_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            param_err_q <= param_err_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_data   = cmd_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign param_err  = param_err_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: drives the serial link in the clk domain and checks decoded traffic.
module tb_lcd_bus_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_sck, lcd_sd, lcd_cs, lcd_rs;
    logic       word_valid, cmd_valid, pix_valid, param_err;
    logic [8:0] word_data;
    logic [7:0] cmd_data;
    logic [15:0] pix_data;
    logic [8:0] pix_x, pix_y;

    always #5 clk = ~clk;

    lcd_bus_rx #(.H_RES(240), .V_RES(320), .COORD_WIDTH(9)) dut (
        .clk(clk), .rst(rst),
        .lcd_sck(lcd_sck), .lcd_sd(lcd_sd), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs),
        .word_valid(word_valid), .word_data(word_data),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .param_err(param_err)
    );

    // Event recorder: counts pulses and logs pixels, sampled on the falling edge.
    int          wv_n = 0, cmd_n = 0, pix_n = 0, pe_n = 0;
    logic [8:0]  last_word = '0;
    logic [7:0]  last_cmd = '0;
    logic [15:0] pq_d[$];
    logic [8:0]  pq_x[$];
    logic [8:0]  pq_y[$];

    always @(negedge clk) begin
        if (word_valid) begin wv_n++; last_word = word_data; end
        if (cmd_valid)  begin cmd_n++; last_cmd = cmd_data; end
        if (pix_valid)  begin pix_n++; pq_d.push_back(pix_data); pq_x.push_back(pix_x); pq_y.push_back(pix_y); end
        if (param_err)  pe_n++;
    end

    int n_cmp = 0, n_fail = 0;
    int b_wv, b_cmd, b_pix, b_pe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_wv = wv_n; b_cmd = cmd_n; b_pix = pix_n; b_pe = pe_n;
    endtask

    task automatic send_bits(input logic rs, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            lcd_sck = 1'b0;
            lcd_sd  = b[7-i];
            lcd_rs  = rs;
            repeat (3) @(negedge clk);
            lcd_sck = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        send_bits(rs, b, 8);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_blip();
        @(negedge clk);
        lcd_cs = 1'b1;
        repeat (5) @(negedge clk);
        lcd_cs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rst(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; lcd_sck = 1'b0; lcd_sd = 1'b0; lcd_cs = 1'b1; lcd_rs = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_data",  32'(word_data),  32'd0);
        check("rst_cmd_valid",  32'(cmd_valid),  32'd0);
        check("rst_cmd_data",   32'(cmd_data),   32'd0);
        check("rst_pix_valid",  32'(pix_valid),  32'd0);
        check("rst_pix_data",   32'(pix_data),   32'd0);
        check("rst_pix_x",      32'(pix_x),      32'd0);
        check("rst_pix_y",      32'(pix_y),      32'd0);
        check("rst_param_err",  32'(param_err),  32'd0);
        lcd_cs = 1'b0;
        repeat (2) @(negedge clk);

        // RAMWR straight after reset: default window starts at (0,0)
        snap();
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hF8);
        send_byte(1'b1, 8'h00);
        settle();
        check("t1_cmd_count", 32'(cmd_n - b_cmd), 32'd1);
        check("t1_cmd_data",  32'(last_cmd), 32'h2C);
        check("t1_word_count", 32'(wv_n - b_wv), 32'd3);
        check("t1_last_word", 32'(last_word), 32'h100);
        check("t1_pix_count", 32'(pix_n - b_pix), 32'd1);
        if (pix_n > b_pix) begin
            check("t1_pix_data", 32'(pq_d[b_pix]), 32'hF800);
            check("t1_pix_x",    32'(pq_x[b_pix]), 32'd0);
            check("t1_pix_y",    32'(pq_y[b_pix]), 32'd0);
        end

        // 2x2 window at (10,5) with wrap back to the origin
        snap();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h0B);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 5; i++) begin
            send_byte(1'b1, 8'(8'hA0 + i));
            send_byte(1'b1, 8'(8'h10 + i));
        end
        settle();
        check("t2_pix_count", 32'(pix_n - b_pix), 32'd5);
        check("t2_no_param_err", 32'(pe_n - b_pe), 32'd0);
        if (pix_n >= b_pix + 5) begin
            logic [8:0] ex [5];
            logic [8:0] ey [5];
            ex = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
            ey = '{9'd5, 9'd5, 9'd6, 9'd6, 9'd5};
            check("t2_pix0_data", 32'(pq_d[b_pix]), 32'hA010);
            check("t2_pix4_data", 32'(pq_d[b_pix+4]), 32'hA414);
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t2_pix%0d_x", i), 32'(pq_x[b_pix+i]), 32'(ex[i]));
                check($sformatf("t2_pix%0d_y", i), 32'(pq_y[b_pix+i]), 32'(ey[i]));
            end
        end

        // CASET cut short after XS: param_err once, XE keeps its 239 reset value
        pulse_rst(2);
        repeat (2) @(negedge clk);
        snap();
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'hEE);
        send_byte(1'b0, 8'h2B);
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b1, 8'h07);
            send_byte(1'b1, 8'(i));
        end
        settle();
        check("t3_param_err_count", 32'(pe_n - b_pe), 32'd1);
        check("t3_pix_count", 32'(pix_n - b_pix), 32'd3);
        if (pix_n >= b_pix + 3) begin
            check("t3_pix0_x", 32'(pq_x[b_pix]),   32'd238);
            check("t3_pix0_y", 32'(pq_y[b_pix]),   32'd0);
            check("t3_pix1_x", 32'(pq_x[b_pix+1]), 32'd239);
            check("t3_pix1_y", 32'(pq_y[b_pix+1]), 32'd0);
            check("t3_pix2_x", 32'(pq_x[b_pix+2]), 32'd238);
            check("t3_pix2_y", 32'(pq_y[b_pix+2]), 32'd1);
        end

        // Partial word dropped by cs deassert (NOP first so A5 is not decoded as pixel data)
        send_byte(1'b0, 8'h00);
        settle();
        snap();
        send_bits(1'b1, 8'hFF, 5);
        cs_blip();
        send_byte(1'b1, 8'hA5);
        settle();
        check("t4_word_count", 32'(wv_n - b_wv), 32'd1);
        check("t4_word_data",  32'(last_word), 32'h1A5);
        check("t4_no_pixel",   32'(pix_n - b_pix), 32'd0);

        // RAMWR survives a cs toggle between the two pixel bytes
        send_byte(1'b0, 8'h2C);
        settle();
        snap();
        send_byte(1'b1, 8'hF8);
        cs_blip();
        send_byte(1'b1, 8'h1F);
        settle();
        check("t5_pix_count", 32'(pix_n - b_pix), 32'd1);
        if (pix_n > b_pix) begin
            check("t5_pix_data", 32'(pq_d[b_pix]), 32'hF81F);
            check("t5_pix_x",    32'(pq_x[b_pix]), 32'd238);
            check("t5_pix_y",    32'(pq_y[b_pix]), 32'd0);
        end

        // Reset mid-RAMWR returns the decoder to IDLE
        send_byte(1'b0, 8'h2C);
        settle();
        pulse_rst(1);
        @(negedge clk);
        snap();
        send_byte(1'b1, 8'h12);
        send_byte(1'b1, 8'h34);
        settle();
        check("t6_no_pixel",   32'(pix_n - b_pix), 32'd0);
        check("t6_word_count", 32'(wv_n - b_wv), 32'd2);
        check("t6_last_word",  32'(last_word), 32'h134);
        check("t6_no_cmd",     32'(cmd_n - b_cmd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
